// File: rtl/sparse_cnn_pkg.sv
// Shared state encoding, default layer geometry and tap decoding for the
// sparse scatter-convolution datapath.
package sparse_cnn_pkg;

    typedef enum logic [1:0] {INIT, IDLE, MAC, DRAIN} state_t;

    localparam int KERNEL_SIZE = 5;
    localparam int IMAGE_SIZE  = 28;
    localparam int OUT         = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam int NTAP        = KERNEL_SIZE * KERNEL_SIZE;

    typedef struct packed {
        logic [7:0] i;
        logic [7:0] j;
    } tap_ij_t;

    function automatic tap_ij_t tap_to_ij(input int t, input int k);
        tap_ij_t ij;
        ij.i = 8'(t / k);
        ij.j = 8'(t % k);
        return ij;
    endfunction

endpackage

// File: rtl/scatter_mac_unit.sv
// Combinational tap decode plus multiply-accumulate for one scatter step.
// Zero latency; no flow control of its own.
module scatter_mac_unit
    import sparse_cnn_pkg::*;
#(
    parameter int CW = 8,
    parameter int WW = 8,
    parameter int AW = 24,
    parameter int K  = KERNEL_SIZE,
    parameter int OD = OUT,
    parameter int TW = $clog2(NTAP),
    parameter int IW = $clog2(OUT * OUT)
) (
    input  logic [CW-1:0]        i_row,
    input  logic [CW-1:0]        i_col,
    input  logic [TW-1:0]        i_tap,
    input  logic [WW-1:0]        i_value,
    input  logic signed [WW-1:0] i_weight,
    input  logic signed [AW-1:0] i_acc,
    output logic                 o_in_range,
    output logic [IW-1:0]        o_idx,
    output logic signed [AW-1:0] o_acc
);
    tap_ij_t              w_ij;
    int                   w_y;
    int                   w_x;
    logic signed [2*WW:0] w_prod;

    always_comb begin
        w_ij       = tap_to_ij(int'(i_tap), K);
        w_y        = int'(i_row) - int'(w_ij.i);
        w_x        = int'(i_col) - int'(w_ij.j);
        o_in_range = (w_y >= 0) && (w_y < OD) && (w_x >= 0) && (w_x < OD);
        o_idx      = IW'(w_y * OD + w_x);
    end

    // Pixel is unsigned, so it gets a zero sign bit before the signed multiply.
    assign w_prod = $signed({1'b0, i_value}) * i_weight;
    assign o_acc  = i_acc + {{(AW-2*WW-1){w_prod[2*WW]}}, w_prod};

endmodule

// File: rtl/sparse_conv_scatter.sv
// Scatter-accumulate valid-mode convolution over a sparse (value,row,col) stream.
// NTAP cycles per entry; result map drains in raster order under out_ready.
module sparse_conv_scatter
    import sparse_cnn_pkg::*;
#(
    parameter int col_length  = 8,
    parameter int word_length = 8,
    parameter int acc_length  = 24,
    parameter int kernel_size = KERNEL_SIZE,
    parameter int image_size  = IMAGE_SIZE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          k_valid,
    input  logic signed [word_length-1:0] k_data,
    output logic                          k_ready,
    input  logic                          nz_valid,
    output logic                          nz_ready,
    input  logic [word_length-1:0]        nz_value,
    input  logic [col_length-1:0]         nz_row,
    input  logic [col_length-1:0]         nz_col,
    input  logic                          nz_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [acc_length-1:0]  out_data,
    output logic                          out_last
);
    localparam int OUT_SZ  = image_size - kernel_size + 1;
    localparam int NTAP_SZ = kernel_size * kernel_size;
    localparam int AREA    = OUT_SZ * OUT_SZ;
    localparam int IW      = $clog2(AREA);
    localparam int TW      = $clog2(NTAP_SZ);

    state_t                        r_state;
    logic [IW-1:0]                 r_idx;
    logic [TW-1:0]                 r_kidx;
    logic [TW-1:0]                 r_tap;
    logic [word_length-1:0]        r_val;
    logic [col_length-1:0]         r_row;
    logic [col_length-1:0]         r_col;
    logic                          r_last;
    logic                          r_last_seen;
    logic                          r_nz_ready;
    logic                          r_out_valid;
    logic                          r_out_last;
    logic signed [word_length-1:0] r_kernel [NTAP_SZ];
    logic signed [acc_length-1:0]  r_acc [AREA];

    logic                          w_nz_fire;
    logic                          w_k_fire;
    logic                          w_in_range;
    logic [IW-1:0]                 w_mac_idx;
    logic signed [acc_length-1:0]  w_acc_rd;
    logic signed [acc_length-1:0]  w_mac_sum;
    logic                          w_wr_en;
    logic [IW-1:0]                 w_wr_idx;
    logic signed [acc_length-1:0]  w_wr_dat;

    // r_nz_ready is high exactly in IDLE; a pending entry blocks kernel writes.
    assign w_nz_fire = nz_valid && r_nz_ready;
    assign k_ready   = r_nz_ready && !r_last_seen && !nz_valid;
    assign w_k_fire  = k_valid && k_ready;
    assign nz_ready  = r_nz_ready;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_valid ? r_acc[r_idx] : '0;
    assign w_acc_rd  = r_acc[w_in_range ? w_mac_idx : '0];

    scatter_mac_unit #(
        .CW (col_length),
        .WW (word_length),
        .AW (acc_length),
        .K  (kernel_size),
        .OD (OUT_SZ),
        .TW (TW),
        .IW (IW)
    ) u_mac (
        .i_row      (r_row),
        .i_col      (r_col),
        .i_tap      (r_tap),
        .i_value    (r_val),
        .i_weight   (r_kernel[r_tap]),
        .i_acc      (w_acc_rd),
        .o_in_range (w_in_range),
        .o_idx      (w_mac_idx),
        .o_acc      (w_mac_sum)
    );

    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = r_idx;
        w_wr_dat = '0;
        case (r_state)
            INIT:    w_wr_en = 1'b1;
            MAC: begin
                w_wr_en  = w_in_range;
                w_wr_idx = w_mac_idx;
                w_wr_dat = w_mac_sum;
            end
            DRAIN:   w_wr_en = out_ready;
            default: w_wr_en = 1'b0;
        endcase
    end

    // Accumulator array has no reset: the INIT sweep zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_acc[w_wr_idx] <= w_wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT;
            r_idx       <= '0;
            r_kidx      <= '0;
            r_tap       <= '0;
            r_val       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_last      <= 1'b0;
            r_last_seen <= 1'b0;
            r_nz_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            for (int t = 0; t < NTAP_SZ; t++) r_kernel[t] <= '0;
        end else begin
            if (w_k_fire) begin
                r_kernel[r_kidx] <= k_data;
                r_kidx <= (r_kidx == TW'(NTAP_SZ - 1)) ? '0 : r_kidx + 1'b1;
            end
            case (r_state)
                INIT: begin
                    if (r_idx == IW'(AREA - 1)) begin
                        r_idx      <= '0;
                        r_nz_ready <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                IDLE: begin
                    if (w_nz_fire) begin
                        r_val       <= nz_value;
                        r_row       <= nz_row;
                        r_col       <= nz_col;
                        r_last      <= nz_last;
                        r_tap       <= '0;
                        r_last_seen <= 1'b1;
                        r_nz_ready  <= 1'b0;
                        r_state     <= MAC;
                    end
                end
                MAC: begin
                    if (r_tap == TW'(NTAP_SZ - 1)) begin
                        r_tap <= '0;
                        if (r_last) begin
                            r_out_valid <= 1'b1;
                            r_out_last  <= (AREA == 1);
                            r_state     <= DRAIN;
                        end else begin
                            r_nz_ready <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (r_idx == IW'(AREA - 1)) begin
                            r_idx       <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_last_seen <= 1'b0;
                            r_nz_ready  <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_idx      <= r_idx + 1'b1;
                            r_out_last <= (r_idx == IW'(AREA - 2));
                        end
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_conv_scatter.sv
// Directed bench for sparse_conv_scatter: hand-computed result maps per scenario.
module tb_sparse_conv_scatter;
    localparam int AREA = 576;
    localparam int NT   = 25;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              k_valid = 1'b0;
    logic signed [7:0] k_data = '0;
    logic              k_ready;
    logic              nz_valid = 1'b0;
    logic              nz_ready;
    logic [7:0]        nz_value = '0;
    logic [7:0]        nz_row = '0;
    logic [7:0]        nz_col = '0;
    logic              nz_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [23:0]       out_data;
    logic              out_last;

    int checks = 0;
    int failures = 0;

    logic [23:0]       got [AREA];
    logic              got_last [AREA];
    logic [23:0]       exp_map [AREA];
    logic signed [7:0] kw [NT];

    always #5 clk = ~clk;

    sparse_conv_scatter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .k_valid   (k_valid),
        .k_data    (k_data),
        .k_ready   (k_ready),
        .nz_valid  (nz_valid),
        .nz_ready  (nz_ready),
        .nz_value  (nz_value),
        .nz_row    (nz_row),
        .nz_col    (nz_col),
        .nz_last   (nz_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    task automatic wait_init(output int n);
        n = -1;
        for (int c = 1; c <= 700; c++) begin
            @(negedge clk);
            if (nz_ready) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic load_kernel(output int refused);
        refused = 0;
        for (int t = 0; t < NT; t++) begin
            @(negedge clk);
            k_valid = 1'b1;
            k_data  = kw[t];
            #1;
            if (!k_ready) refused++;
        end
        @(negedge clk);
        k_valid = 1'b0;
    endtask

    // gap = negedges from the handshake until nz_ready or out_valid returns.
    task automatic send_nz(input logic [7:0] v, input logic [7:0] r, input logic [7:0] c,
                           input logic l, input logic kv, output int gap, output logic kr);
        @(negedge clk);
        nz_valid = 1'b1; nz_value = v; nz_row = r; nz_col = c; nz_last = l;
        k_valid = kv; k_data = 8'sd50;
        gap = -1;
        kr  = 1'b0;
        for (int w = 0; w < 100 && !nz_ready; w++) @(negedge clk);
        if (nz_ready) begin
            #1 kr = k_ready;
            for (int n = 1; n <= 40; n++) begin
                @(negedge clk);
                if (n == 1) begin
                    nz_valid = 1'b0;
                    k_valid  = 1'b0;
                end
                if (nz_ready || out_valid) begin
                    gap = n;
                    break;
                end
            end
        end
        nz_valid = 1'b0;
        k_valid  = 1'b0;
    endtask

    task automatic drain(input bit stall, output int beats, output int unstable);
        int          cyc;
        logic [23:0] held;
        bit          holding;
        beats = 0; unstable = 0; holding = 0; cyc = 0; held = '0;
        for (int i = 0; i < AREA; i++) begin
            got[i] = 'x;
            got_last[i] = 1'bx;
        end
        while (beats < AREA && cyc < 4 * AREA + 100) begin
            if (holding) begin
                if (!out_valid || out_data !== held) unstable++;
                holding = 0;
            end
            out_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (out_valid && out_ready) begin
                got[beats] = out_data;
                got_last[beats] = out_last;
                beats++;
            end else if (out_valid) begin
                held = out_data;
                holding = 1;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
    endtask

    function automatic void clear_exp();
        for (int i = 0; i < AREA; i++) exp_map[i] = '0;
    endfunction

    function automatic int count_bad(output int first);
        int bad = 0;
        first = -1;
        for (int i = 0; i < AREA; i++)
            if (got[i] !== exp_map[i]) begin
                if (first < 0) first = i;
                bad++;
            end
        return bad;
    endfunction

    function automatic int count_last();
        int n = 0;
        for (int i = 0; i < AREA; i++) if (got_last[i] === 1'b1) n++;
        return n;
    endfunction

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (k_ready !== 0 || nz_ready !== 0 || out_valid !== 0 || out_last !== 0) begin
            failures++;
            $display("FAIL reset_ctrl k_ready=%b nz_ready=%b out_valid=%b out_last=%b, want all 0",
                     k_ready, nz_ready, out_valid, out_last);
        end
        checks++;
        if (out_data !== 24'd0) begin
            failures++;
            $display("FAIL reset_data got %h want 0", out_data);
        end
        rst_n = 1'b1;
        wait_init(n);
        checks++;
        if (n !== 576) begin
            failures++;
            $display("FAIL init_cycles got %0d want 576", n);
        end
        checks++;
        if (k_ready !== 1'b1) begin
            failures++;
            $display("FAIL k_ready_idle got %b want 1", k_ready);
        end
    endtask

    task automatic test_ones_kernel();
        int gap, beats, unst, first, bad, refused;
        logic kr;
        for (int t = 0; t < NT; t++) kw[t] = 8'sd1;
        load_kernel(refused);
        checks++;
        if (refused !== 0) begin
            failures++;
            $display("FAIL ones_kload refused %0d of 25 want 0", refused);
        end
        send_nz(8'd3, 8'd2, 8'd2, 1'b1, 1'b0, gap, kr);
        checks++;
        if (gap !== 26) begin
            failures++;
            $display("FAIL ones_latency got %0d cycles want 26", gap);
        end
        drain(1'b0, beats, unst);
        checks++;
        if (beats !== AREA) begin
            failures++;
            $display("FAIL ones_beats got %0d want 576", beats);
        end
        clear_exp();
        for (int y = 0; y < 3; y++) for (int x = 0; x < 3; x++) exp_map[y*24+x] = 24'd3;
        bad = count_bad(first);
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL ones_map %0d bad, first idx %0d got %h want %h",
                     bad, first, got[first], exp_map[first]);
        end
        checks++;
        if (count_last() !== 1 || got_last[AREA-1] !== 1'b1) begin
            failures++;
            $display("FAIL ones_last count %0d final %b want 1 and 1", count_last(), got_last[AREA-1]);
        end
    endtask

    task automatic test_sparse_taps();
        int gap, beats, unst, first, bad, refused;
        logic kr;
        for (int t = 0; t < NT; t++) kw[t] = 8'sd0;
        kw[0]  = 8'sd7;
        kw[24] = -8'sd2;
        load_kernel(refused);
        send_nz(8'd5, 8'd0, 8'd0, 1'b0, 1'b0, gap, kr);
        checks++;
        if (gap !== 26) begin
            failures++;
            $display("FAIL taps_entry0_cycles got %0d want 26", gap);
        end
        checks++;
        if (k_ready !== 1'b0) begin
            failures++;
            $display("FAIL taps_k_ready_midframe got %b want 0", k_ready);
        end
        send_nz(8'd4, 8'd27, 8'd27, 1'b1, 1'b0, gap, kr);
        checks++;
        if (gap !== 26) begin
            failures++;
            $display("FAIL taps_entry1_cycles got %0d want 26", gap);
        end
        drain(1'b0, beats, unst);
        clear_exp();
        exp_map[0]   = 24'd35;
        exp_map[575] = 24'hFFFFF8;
        bad = count_bad(first);
        checks++;
        if (bad !== 0 || beats !== AREA) begin
            failures++;
            $display("FAIL taps_map %0d bad beats %0d, first idx %0d got %h want %h",
                     bad, beats, first, got[first], exp_map[first]);
        end
    endtask

    task automatic test_stall_clear();
        int gap, beats, unst, first, bad;
        logic kr;
        send_nz(8'd1, 8'd10, 8'd10, 1'b1, 1'b0, gap, kr);
        drain(1'b1, beats, unst);
        checks++;
        if (unst !== 0) begin
            failures++;
            $display("FAIL stall_stability %0d unstable stalls want 0", unst);
        end
        clear_exp();
        exp_map[10*24+10] = 24'd7;
        exp_map[6*24+6]   = 24'hFFFFFE;
        bad = count_bad(first);
        checks++;
        if (bad !== 0 || beats !== AREA) begin
            failures++;
            $display("FAIL stall_map %0d bad beats %0d, first idx %0d got %h want %h",
                     bad, beats, first, got[first], exp_map[first]);
        end
        checks++;
        if (k_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_kload_reenabled got %b want 1", k_ready);
        end
        send_nz(8'd2, 8'd0, 8'd0, 1'b1, 1'b0, gap, kr);
        drain(1'b0, beats, unst);
        clear_exp();
        exp_map[0] = 24'd14;
        bad = count_bad(first);
        checks++;
        if (bad !== 0 || beats !== AREA) begin
            failures++;
            $display("FAIL clear_on_read %0d bad beats %0d, first idx %0d got %h want %h",
                     bad, beats, first, got[first], exp_map[first]);
        end
    endtask

    task automatic test_wrap();
        int gap, beats, unst, first, bad, refused, badgap;
        int wrapped;
        logic kr;
        for (int t = 0; t < NT; t++) kw[t] = 8'sd127;
        load_kernel(refused);
        badgap = 0;
        for (int e = 0; e < 1000; e++) begin
            send_nz(8'd255, 8'd4, 8'd4, 1'b0, 1'b0, gap, kr);
            if (gap !== 26) badgap++;
        end
        checks++;
        if (badgap !== 0) begin
            failures++;
            $display("FAIL wrap_entry_cycles %0d entries off 26 want 0", badgap);
        end
        send_nz(8'd0, 8'd4, 8'd4, 1'b1, 1'b0, gap, kr);
        drain(1'b0, beats, unst);
        wrapped = -1169432;
        clear_exp();
        for (int y = 0; y < 5; y++) for (int x = 0; x < 5; x++) exp_map[y*24+x] = wrapped[23:0];
        bad = count_bad(first);
        checks++;
        if (bad !== 0 || beats !== AREA) begin
            failures++;
            $display("FAIL wrap_map %0d bad beats %0d, first idx %0d got %h want %h",
                     bad, beats, first, got[first], exp_map[first]);
        end
    endtask

    task automatic test_reset_mid_mac();
        int n, gap, beats, unst, first, bad, refused;
        logic kr;
        @(negedge clk);
        nz_valid = 1'b1; nz_value = 8'd5; nz_row = 8'd5; nz_col = 8'd5; nz_last = 1'b0;
        @(negedge clk);
        nz_valid = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (nz_ready !== 1'b0) begin
            failures++;
            $display("FAIL midmac_busy nz_ready %b want 0", nz_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (k_ready !== 0 || nz_ready !== 0 || out_valid !== 0 || out_data !== 24'd0) begin
            failures++;
            $display("FAIL midmac_reset_outputs k_ready=%b nz_ready=%b out_valid=%b data=%h want 0",
                     k_ready, nz_ready, out_valid, out_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_init(n);
        checks++;
        if (n !== 576) begin
            failures++;
            $display("FAIL midmac_init_cycles got %0d want 576", n);
        end
        send_nz(8'd9, 8'd12, 8'd12, 1'b1, 1'b0, gap, kr);
        drain(1'b0, beats, unst);
        clear_exp();
        bad = count_bad(first);
        checks++;
        if (bad !== 0 || beats !== AREA) begin
            failures++;
            $display("FAIL midmac_kernel_cleared %0d bad beats %0d, first idx %0d got %h want 0",
                     bad, beats, first, got[first]);
        end
        for (int t = 0; t < NT; t++) kw[t] = 8'sd1;
        load_kernel(refused);
        send_nz(8'd3, 8'd2, 8'd2, 1'b1, 1'b0, gap, kr);
        drain(1'b0, beats, unst);
        for (int y = 0; y < 3; y++) for (int x = 0; x < 3; x++) exp_map[y*24+x] = 24'd3;
        bad = count_bad(first);
        checks++;
        if (bad !== 0 || beats !== AREA || refused !== 0) begin
            failures++;
            $display("FAIL midmac_rerun %0d bad beats %0d refused %0d, first idx %0d got %h want %h",
                     bad, beats, refused, first, got[first], exp_map[first]);
        end
    endtask

    task automatic test_empty_collision();
        int gap, beats, unst, first, bad;
        logic kr;
        send_nz(8'd0, 8'd0, 8'd0, 1'b1, 1'b1, gap, kr);
        checks++;
        if (kr !== 1'b0) begin
            failures++;
            $display("FAIL collision_k_ready got %b want 0", kr);
        end
        drain(1'b0, beats, unst);
        clear_exp();
        bad = count_bad(first);
        checks++;
        if (bad !== 0 || beats !== AREA) begin
            failures++;
            $display("FAIL empty_frame %0d bad beats %0d, first idx %0d got %h want 0",
                     bad, beats, first, got[first]);
        end
        send_nz(8'd1, 8'd0, 8'd0, 1'b1, 1'b0, gap, kr);
        drain(1'b0, beats, unst);
        exp_map[0] = 24'd1;
        bad = count_bad(first);
        checks++;
        if (bad !== 0 || beats !== AREA) begin
            failures++;
            $display("FAIL collision_kernel_kept %0d bad beats %0d, first idx %0d got %h want %h",
                     bad, beats, first, got[first], exp_map[first]);
        end
    endtask

    initial begin
        test_reset();
        test_ones_kernel();
        test_sparse_taps();
        test_stall_clear();
        test_wrap();
        test_reset_mid_mac();
        test_empty_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
